// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Checksum support is selected with UART_LOADER_CHECKSUM_EN (see uart_loader.sv).
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Number of bytes needed to carry an address of the given bit width.
    function automatic int addr_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_byte_fetch.sv
// One-outstanding-read handshake with the UART RX FIFO; presents each fetched
// byte to the parser as a single-cycle byte_valid strobe.
module uart_byte_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_read,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic pending_reg;

    // A new pop is only issued once the previous byte has been delivered.
    assign rx_read    = en && !rx_empty && !pending_reg && !rst;
    assign byte_valid = pending_reg && en;
    assign byte_data  = rx_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
        end else begin
            pending_reg <= rx_read;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Framed serial image loader: SYNC, ADDR, LEN, data words (LE), optional CSUM.
// Define UART_LOADER_CHECKSUM_EN to expect and verify the trailing checksum byte.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH = 16,
    parameter int         WORD_BYTES = 4,
    parameter int         LEN_BYTES  = 2,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_en,
    input  logic                    in_rx_empty,
    input  logic [7:0]              in_rx_data,
    output logic                    out_rx_read,
    output logic                    out_mem_we,
    output logic [ADDR_WIDTH-1:0]   out_mem_addr,
    output logic [8*WORD_BYTES-1:0] out_mem_data,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_err
);

    localparam int         WORD_WIDTH = 8 * WORD_BYTES;
    localparam int         ADDR_BYTES = addr_bytes(ADDR_WIDTH);
    localparam int         ADDR_BUF_W = 8 * ADDR_BYTES;
    localparam int         LEN_W      = 8 * LEN_BYTES;
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BYTES - 1);
    localparam logic [7:0] LEN_LAST   = 8'(LEN_BYTES - 1);
    localparam logic [7:0] WORD_LAST  = 8'(WORD_BYTES - 1);

`ifdef UART_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    logic                  byte_valid;
    logic [7:0]            byte_data;

    state_t                state_reg, state_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic [ADDR_BUF_W-1:0] addr_buf_reg, addr_buf_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]      len_reg, len_next;
    logic [WORD_WIDTH-1:0] word_reg, word_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic [WORD_WIDTH-1:0] mem_data_reg, mem_data_next;

    uart_byte_fetch u_fetch (
        .clk        (in_clk),
        .rst        (in_rst),
        .en         (in_en),
        .rx_empty   (in_rx_empty),
        .rx_data    (in_rx_data),
        .rx_read    (out_rx_read),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] sum_reg;

    // Running sum restarts whenever the parser is back in IDLE waiting for SYNC.
    always_ff @(posedge in_clk) begin
        if (in_rst || state_reg == IDLE) begin
            sum_reg <= 8'd0;
        end else if (byte_valid && (state_reg == ADDR || state_reg == LEN || state_reg == DATA)) begin
            sum_reg <= sum_reg + byte_data;
        end
    end

    assign out_err = (state_reg == ERR);
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_buf_reg <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            word_reg     <= '0;
            we_reg       <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_buf_reg <= addr_buf_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            word_reg     <= word_next;
            we_reg       <= we_next;
            mem_addr_reg <= mem_addr_next;
            mem_data_reg <= mem_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_buf_next = addr_buf_reg;
        addr_next     = addr_reg;
        len_next      = len_reg;
        word_next     = word_reg;
        we_next       = 1'b0;
        mem_addr_next = mem_addr_reg;
        mem_data_next = mem_data_reg;

        if (!in_en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        state_next = ADDR;
                        cnt_next   = '0;
                    end
                end
                ADDR: begin
                    if (byte_valid) begin
                        // Little-endian: each new byte enters at the top and shifts down.
                        addr_buf_next = ADDR_BUF_W'({byte_data, addr_buf_reg} >> 8);
                        if (cnt_reg == ADDR_LAST) begin
                            addr_next  = addr_buf_next[ADDR_WIDTH-1:0];
                            cnt_next   = '0;
                            state_next = LEN;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                LEN: begin
                    if (byte_valid) begin
                        len_next = LEN_W'({byte_data, len_reg} >> 8);
                        if (cnt_reg == LEN_LAST) begin
                            cnt_next   = '0;
                            state_next = (len_next == '0) ? END_STATE : DATA;
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        word_next = WORD_WIDTH'({byte_data, word_reg} >> 8);
                        if (cnt_reg == WORD_LAST) begin
                            cnt_next      = '0;
                            we_next       = 1'b1;
                            mem_addr_next = addr_reg;
                            mem_data_next = word_next;
                            addr_next     = addr_reg + 1'b1;
                            len_next      = len_reg - 1'b1;
                            if (len_reg == LEN_W'(1)) begin
                                state_next = END_STATE;
                            end
                        end else begin
                            cnt_next = cnt_reg + 8'd1;
                        end
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (byte_valid) begin
                        state_next = (byte_data == sum_reg) ? DONE : ERR;
                    end
                end
`endif
                DONE:    state_next = IDLE;
                ERR:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign out_mem_we   = we_reg;
    assign out_mem_addr = mem_addr_reg;
    assign out_mem_data = mem_data_reg;
    assign out_busy     = (state_reg != IDLE);
    assign out_done     = (state_reg == DONE);

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: frames are built from byte lists, expected
// writes/done/err are queued at issue time and a monitor checks DUT events.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rx_empty;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    uart_loader dut (
        .in_clk       (clk),
        .in_rst       (rst),
        .in_en        (en),
        .in_rx_empty  (rx_empty),
        .in_rx_data   (rx_data),
        .out_rx_read  (rx_read),
        .out_mem_we   (mem_we),
        .out_mem_addr (mem_addr),
        .out_mem_data (mem_data),
        .out_busy     (busy),
        .out_done     (done),
        .out_err      (err)
    );

    // Behavioural RX FIFO: data appears the cycle after a pop.
    logic [7:0] fifo_mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rx_empty = (wr_ptr == rd_ptr);

    initial rx_data = 8'h00;

    always @(posedge clk) begin
        if (rx_read) begin
            rx_data <= fifo_mem[rd_ptr & 4095];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] words_q[$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic check_ev(input int kind, input logic [15:0] a, input logic [31:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_WR && (e.addr != a || e.data != d))) begin
                fails++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end else begin
                $display("[TB] event kind=%0d addr=%h data=%h ok", kind, a, d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) check_ev(EV_WR, mem_addr, mem_data);
            if (done)   check_ev(EV_DONE, 16'h0, 32'h0);
            if (err)    check_ev(EV_ERR, 16'h0, 32'h0);
            if (done && err) begin
                tests++;
                fails++;
                $display("FAIL done_err_overlap: got done=1 err=1, required not both");
            end
        end
    end

    task automatic put(input logic [7:0] b);
        fifo_mem[wr_ptr & 4095] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_fifo_drained();
        int n;
        n = 0;
        while (!rx_empty && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("fifo_drain_timeout", 64'(rx_empty), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((!rx_empty || exp_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Frame model: checksum is the 8-bit sum of address, length and data bytes.
    task automatic issue_frame(input logic [15:0] addr, input bit corrupt,
                               input int max_gap, input int starve_at);
        logic [7:0]  bytes_q[$];
        logic [7:0]  sum;
        logic [15:0] n;
        logic [15:0] a;
        ev_t         e;
        int          w;
        bytes_q = {};
        sum     = 8'h00;
        n       = 16'(words_q.size());
        bytes_q.push_back(8'hA5);
        bytes_q.push_back(addr[7:0]);
        bytes_q.push_back(addr[15:8]);
        bytes_q.push_back(n[7:0]);
        bytes_q.push_back(n[15:8]);
        foreach (words_q[i]) begin
            for (int b = 0; b < 4; b++) bytes_q.push_back(words_q[i][8*b +: 8]);
        end
        for (int i = 1; i < bytes_q.size(); i++) sum = sum + bytes_q[i];
`ifdef UART_LOADER_CHECKSUM_EN
        bytes_q.push_back(corrupt ? sum + 8'd1 : sum);
`endif
        a = addr;
        foreach (words_q[i]) begin
            e.kind = EV_WR;
            e.addr = a;
            e.data = words_q[i];
            exp_q.push_back(e);
            a = a + 16'd1;
        end
        e.addr = 16'h0;
        e.data = 32'h0;
`ifdef UART_LOADER_CHECKSUM_EN
        e.kind = corrupt ? EV_ERR : EV_DONE;
`else
        e.kind = EV_DONE;
`endif
        exp_q.push_back(e);
        $display("[TB] frame addr=%h words=%0d corrupt=%0d csum=%h", addr, n, corrupt, sum);
        for (int i = 0; i < bytes_q.size(); i++) begin
            if (i == starve_at) begin
                wait_fifo_drained();
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    check("starve_read", 64'(rx_read), 64'd0);
                end
            end
            w = $urandom_range(0, max_gap);
            repeat (w) @(negedge clk);
            put(bytes_q[i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_read", 64'(rx_read), 64'd0);
        check("reset_mem_we", 64'(mem_we), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_mem_data", 64'(mem_data), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal two-word frame, then the same frame with a bad checksum.
        words_q = '{32'h44332211, 32'h88776655};
        issue_frame(16'h0010, 1'b0, 0, -1);
        wait_idle();
        issue_frame(16'h0010, 1'b1, 0, -1);
        wait_idle();

        // Garbage before SYNC, then a zero-length frame.
        put(8'h00); put(8'hFF); put(8'h5A);
        words_q = {};
        issue_frame(16'h0000, 1'b0, 0, -1);
        wait_idle();

        // Address wrap.
        words_q = '{32'hDEADBEEF, 32'h01234567};
        issue_frame(16'hFFFF, 1'b0, 1, -1);
        wait_idle();

        // Enable dropped after the second data byte of word 0.
        put(8'hA5); put(8'h20); put(8'h00); put(8'h01); put(8'h00); put(8'hAA); put(8'hBB);
        wait_fifo_drained();
        check("abort_busy_before", 64'(busy), 64'd1);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy_after", 64'(busy), 64'd0);
        en = 1'b1;
        words_q = '{32'hCAFEF00D};
        issue_frame(16'h0030, 1'b0, 0, -1);
        wait_idle();

        // Reset in the middle of a word.
        put(8'hA5); put(8'h40); put(8'h00); put(8'h01); put(8'h00); put(8'h01); put(8'h02); put(8'h03);
        wait_fifo_drained();
        check("rst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy_after", 64'(busy), 64'd0);
        check("rst_no_write", 64'(mem_we), 64'd0);

        // FIFO starved for 50 cycles after two data bytes of word 0.
        words_q = '{32'h44332211, 32'h88776655};
        issue_frame(16'h0100, 1'b0, 0, 7);
        wait_idle();

        // Randomised frames, including back-to-back and corrupted ones.
        for (int f = 0; f < 20; f++) begin
            int nw;
            nw = $urandom_range(0, 5);
            words_q = {};
            for (int i = 0; i < nw; i++) words_q.push_back($urandom);
            issue_frame(16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), -1);
            if (f % 3 == 2) wait_idle();
        end
        wait_idle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
